// File: rtl/quad_pkg.sv
// Shared types and Gray-code successor table
// for the quadrature decoder.
package quad_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    typedef logic [1:0] phase_t;

    localparam phase_t FWD_SUCC_00 = 2'b01;
    localparam phase_t FWD_SUCC_01 = 2'b11;
    localparam phase_t FWD_SUCC_11 = 2'b10;
    localparam phase_t FWD_SUCC_10 = 2'b00;

    function automatic phase_t fwd_succ(phase_t p);
        phase_t r;
        unique case (p)
            2'b00:   r = FWD_SUCC_00;
            2'b01:   r = FWD_SUCC_01;
            2'b11:   r = FWD_SUCC_11;
            default: r = FWD_SUCC_10;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/glitch_filter.sv
// Per-channel synchronizer and stability filter.
// acc_level/acc_valid are the values accepted at the coming edge.
module glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic acc_level,
    output logic acc_valid
);

    localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic                   cand_q;
    logic                   level_q;
    logic                   primed_q;
    logic [3:0]             cnt_q;
    logic [3:0]             cnt_d;

    assign sample = sync_q[SYNC_STAGES-1];

    // Run counter: restart on any disagreement, accept on the last sample.
    always_comb begin
        acc_level = level_q;
        acc_valid = primed_q;
        cnt_d     = cnt_q;
        if (primed_q && (sample == level_q)) begin
            cnt_d = '0;
        end else if ((cnt_q != '0) && (sample != cand_q)) begin
            cnt_d = 4'd1;
        end else if (cnt_q == LAST) begin
            acc_level = sample;
            acc_valid = 1'b1;
            cnt_d     = '0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Synchronizer chain and filter state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cand_q   <= 1'b0;
            level_q  <= 1'b0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
            cand_q   <= sample;
            level_q  <= acc_level;
            primed_q <= acc_valid;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filtered A/B channels drive a
// two-state tracker emitting step and error pulses.
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int INVERT_DIR  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       dec_en,
    input  logic       err_clr,
    output logic       step_valid,
    output logic       step_dir,
    output logic [1:0] phase,
    output logic       err_pulse,
    output logic       err_flag
);

    localparam logic INV = (INVERT_DIR != 0);

    logic   a_lvl;
    logic   a_ok;
    logic   b_lvl;
    logic   b_ok;
    state_t state_q;
    state_t state_d;
    phase_t ph_new;
    phase_t phase_d;
    logic   up;
    logic   sv_d;
    logic   sd_d;
    logic   ep_d;
    logic   ef_d;

    glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (enc_a),
        .acc_level(a_lvl),
        .acc_valid(a_ok)
    );

    glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (enc_b),
        .acc_level(b_lvl),
        .acc_valid(b_ok)
    );

    assign ph_new = {a_lvl, b_lvl};

    // Next state: initial load, then classify each phase change.
    always_comb begin
        state_d = state_q;
        phase_d = phase;
        sv_d    = 1'b0;
        sd_d    = 1'b0;
        ep_d    = 1'b0;
        ef_d    = err_flag & ~err_clr;
        up      = (ph_new == fwd_succ(phase));
        unique case (state_q)
            ST_INIT: begin
                if (a_ok && b_ok) begin
                    state_d = ST_TRACK;
                    phase_d = ph_new;
                end
            end
            ST_TRACK: begin
                phase_d = ph_new;
                if (ph_new != phase) begin
                    if (^(ph_new ^ phase)) begin
                        sv_d = dec_en;
                        sd_d = dec_en & (up ^ INV);
                    end else begin
                        ep_d = 1'b1;
                        ef_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            phase      <= 2'b00;
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            err_pulse  <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase      <= phase_d;
            step_valid <= sv_d;
            step_dir   <= sd_d;
            err_pulse  <= ep_d;
            err_flag   <= ef_d;
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder with a
// second instance built with INVERT_DIR = 1.
module tb_quadrature_decoder;
    import quad_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enc_a;
    logic       enc_b;
    logic       dec_en;
    logic       err_clr;
    logic       step_valid;
    logic       step_dir;
    logic [1:0] phase;
    logic       err_pulse;
    logic       err_flag;
    logic       i_valid;
    logic       i_dir;
    logic [1:0] i_phase;
    logic       i_ep;
    logic       i_ef;

    int n_tests = 0;
    int n_fail  = 0;
    int n_up    = 0;
    int n_dn    = 0;
    int n_err   = 0;
    int n_dirx  = 0;
    int i_up    = 0;
    int i_dn    = 0;
    int s_up, s_dn, s_err, s_iup, s_idn;

    quadrature_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .dec_en    (dec_en),
        .err_clr   (err_clr),
        .step_valid(step_valid),
        .step_dir  (step_dir),
        .phase     (phase),
        .err_pulse (err_pulse),
        .err_flag  (err_flag)
    );

    quadrature_decoder #(.INVERT_DIR(1)) dut_inv (
        .clk       (clk),
        .rst_n     (rst_n),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .dec_en    (dec_en),
        .err_clr   (err_clr),
        .step_valid(i_valid),
        .step_dir  (i_dir),
        .phase     (i_phase),
        .err_pulse (i_ep),
        .err_flag  (i_ef)
    );

    always #5 clk = ~clk;

    // Downstream counter and pulse bookkeeping.
    always @(negedge clk) begin
        if (step_valid && step_dir)  n_up++;
        if (step_valid && !step_dir) n_dn++;
        if (!step_valid && step_dir) n_dirx++;
        if (err_pulse)               n_err++;
        if (i_valid && i_dir)        i_up++;
        if (i_valid && !i_dir)       i_dn++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input logic [1:0] v);
        {enc_a, enc_b} = v;
    endtask

    task automatic snap();
        s_up  = n_up;
        s_dn  = n_dn;
        s_err = n_err;
        s_iup = i_up;
        s_idn = i_dn;
    endtask

    initial begin
        rst_n   = 1'b0;
        enc_a   = 1'b0;
        enc_b   = 1'b0;
        dec_en  = 1'b1;
        err_clr = 1'b0;
        tick(3);
        check("rst_phase", 32'(phase), 0);
        check("rst_valid", 32'(step_valid), 0);
        check("rst_dir", 32'(step_dir), 0);
        check("rst_eflag", 32'(err_flag), 0);
        check("rst_state", 32'(dut.state_q), 32'(ST_INIT));

        rst_n = 1'b1;
        tick(10);
        check("idle_phase", 32'(phase), 0);
        check("idle_state", 32'(dut.state_q), 32'(ST_TRACK));
        check("idle_steps", 32'(n_up + n_dn), 0);

        snap();
        set_ab(2'b01);
        tick(4);
        check("lat_e4_phase", 32'(phase), 0);
        check("lat_e4_valid", 32'(step_valid), 0);
        tick(1);
        check("lat_e5_phase", 32'(phase), 1);
        check("lat_e5_valid", 32'(step_valid), 1);
        check("lat_e5_dir", 32'(step_dir), 1);
        tick(1);
        check("lat_e6_valid", 32'(step_valid), 0);
        tick(2);
        set_ab(2'b11); tick(8);
        set_ab(2'b10); tick(8);
        set_ab(2'b00); tick(8);
        check("fwd_up", 32'(n_up - s_up), 4);
        check("fwd_dn", 32'(n_dn - s_dn), 0);
        check("fwd_count", 32'((n_up - n_dn) - (s_up - s_dn)), 4);
        check("fwd_inv_dn", 32'(i_dn - s_idn), 4);
        check("fwd_phase", 32'(phase), 0);

        snap();
        set_ab(2'b10); tick(8);
        set_ab(2'b11); tick(8);
        set_ab(2'b01); tick(8);
        set_ab(2'b00); tick(8);
        check("rev_dn", 32'(n_dn - s_dn), 4);
        check("rev_up", 32'(n_up - s_up), 0);
        check("rev_inv_up", 32'(i_up - s_iup), 4);

        snap();
        enc_a = 1'b1; tick(2);
        enc_a = 1'b0; tick(10);
        check("glitch_phase", 32'(phase), 0);
        check("glitch_steps", 32'((n_up + n_dn) - (s_up + s_dn)), 0);

        snap();
        set_ab(2'b11);
        tick(5);
        check("err_e5_pulse", 32'(err_pulse), 1);
        check("err_e5_phase", 32'(phase), 3);
        tick(3);
        check("err_count", 32'(n_err - s_err), 1);
        check("err_flag", 32'(err_flag), 1);
        check("err_steps", 32'((n_up + n_dn) - (s_up + s_dn)), 0);
        err_clr = 1'b1; tick(1);
        err_clr = 1'b0;
        check("err_clr", 32'(err_flag), 0);

        set_ab(2'b00);
        tick(4);
        err_clr = 1'b1; tick(1);
        err_clr = 1'b0;
        check("clr_vs_err", 32'(err_flag), 1);
        check("clr_vs_err_ph", 32'(phase), 0);
        tick(3);

        snap();
        dec_en = 1'b0;
        set_ab(2'b01); tick(8);
        dec_en = 1'b1; tick(3);
        check("den_phase", 32'(phase), 1);
        check("den_steps", 32'((n_up + n_dn) - (s_up + s_dn)), 0);

        set_ab(2'b11);
        tick(3);
        rst_n = 1'b0; tick(1);
        check("mid_rst_phase", 32'(phase), 0);
        check("mid_rst_eflag", 32'(err_flag), 0);
        check("mid_rst_valid", 32'(step_valid), 0);
        check("mid_rst_state", 32'(dut.state_q), 32'(ST_INIT));
        snap();
        rst_n = 1'b1; tick(10);
        check("reinit_phase", 32'(phase), 3);
        check("reinit_state", 32'(dut.state_q), 32'(ST_TRACK));
        check("reinit_steps", 32'((n_up + n_dn) - (s_up + s_dn)), 0);
        check("reinit_err", 32'(n_err - s_err), 0);

        set_ab(2'b10); tick(8);
        check("post_up", 32'(n_up - s_up), 1);
        check("dir_idle_zero", 32'(n_dirx), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
